// File: rtl/partial_product_shifter.sv
// Chunk-granular shifter: loads operand, shifts CHUNK bits per cycle, result valid in_amt+1 cycles after accept.
// Holds result in DONE until out_ready; PPS_SHIFT_RIGHT_EN enables in_dir right shifts, else left only.
module partial_product_shifter #(
    parameter int IN_W  = 48,
    parameter int OUT_W = 64,
    parameter int CHUNK = 16,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_next;
    logic [OUT_W-1:0] in_ext;
    logic [AMT_W-1:0] cnt;
    logic             accept;

    always_comb begin
        in_ext             = '0;
        in_ext[IN_W-1:0]   = in_data;
    end

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign busy      = (state != IDLE);

`ifdef PPS_SHIFT_RIGHT_EN
    logic dir;

    always_comb begin
        acc_next = dir ? (acc >> CHUNK) : (acc << CHUNK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dir <= 1'b0;
        else if (accept)
            dir <= in_dir;
    end
`else
    logic unused_dir;
    assign unused_dir = in_dir;

    always_comb begin
        acc_next = acc << CHUNK;
    end
`endif

    // A zero-count request skips SHIFT and is presented the cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            acc   <= in_ext;
            cnt   <= in_amt;
            state <= (in_amt == '0) ? DONE : SHIFT;
        end else if (state == SHIFT) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (cnt == AMT_W'(1))
                state <= DONE;
        end else if (state == DONE) begin
            if (out_ready)
                state <= IDLE;
        end else if (state != IDLE) begin
            state <= IDLE;
        end
    end

endmodule

// File: doc/partial_product_shifter.md
PARTIAL_PRODUCT_SHIFTER -- requirements
Module: partial_product_shifter

Interface
REQ-001 SHALL have parameter IN_W, default 48, input operand width in bits.
REQ-002 SHALL have parameter OUT_W, default 64, output width in bits; OUT_W >= IN_W.
REQ-003 SHALL have parameter CHUNK, default 16, shift granule in bits.
REQ-004 SHALL have parameter AMT_W, default 2, width of shift-count field in chunks.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-009 SHALL have port in_data  input  IN_W  operand.
REQ-010 SHALL have port in_amt  input  AMT_W  shift count in CHUNK units, 0..2^AMT_W-1.
REQ-011 SHALL have port in_dir  input  1  0 = left, 1 = logical right (see REQ-030).
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port out_data  output  OUT_W  shifted result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 Request accept SHALL occur on a rising edge where in_valid && in_ready.
REQ-017 On accept, the block SHALL load acc = in_data zero-extended to OUT_W, cnt = in_amt and latch dir.
REQ-018 FSM SHALL have states IDLE, SHIFT, DONE.
REQ-019 Transitions: IDLE->SHIFT on accept with in_amt != 0; IDLE->DONE on accept with in_amt == 0; SHIFT->DONE when cnt == 1; DONE->IDLE on out_ready without new accept; DONE->SHIFT/DONE on simultaneous out_ready and accept, per in_amt.
REQ-020 Each SHIFT cycle SHALL shift acc by exactly CHUNK bits in latched direction, zero-filled, truncated to OUT_W, and decrement cnt.
REQ-021 Result SHALL equal (zext(in_data) << in_amt*CHUNK) mod 2^OUT_W for left, or zext(in_data) >> in_amt*CHUNK for right.
REQ-022 out_valid SHALL rise in_amt+1 cycles after the accept edge; minimum latency 1 cycle.
REQ-023 out_valid SHALL be high only in DONE, with out_data = acc.
REQ-024 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-025 in_ready SHALL be (state == IDLE) || (state == DONE && out_ready); no request accepted during SHIFT.
REQ-026 in_data, in_amt and in_dir SHALL be ignored outside accept edges.
REQ-027 Shifts totalling >= OUT_W bits SHALL yield all-zero out_data without error.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, acc 0, cnt 0, out_valid 0, out_data 0, busy 0, in_ready 1 (after release, independent of clk).
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL discard the in-flight operation; no result appears after release.

Configuration
REQ-030 With macro PPS_SHIFT_RIGHT_EN defined, in_dir SHALL select direction per REQ-011; without it, in_dir SHALL be ignored, all operations SHALL shift left and no right-shift logic SHALL be synthesised.

Verification
REQ-031 Left, amt=1: in_data=48'h0000_0000_ABCD -> out_valid 2 cycles after accept, out_data=64'h0000_0000_ABCD_0000.
REQ-032 Left, amt=3: in_data=48'h1234_5678_9ABC -> out_valid 4 cycles after accept, out_data=64'h9ABC_0000_0000_0000; amt=0 -> next cycle out_data=64'h0000_1234_5678_9ABC.
REQ-033 PPS_SHIFT_RIGHT_EN defined, in_dir=1, amt=1, in_data=48'hFFFF_0000_1234 -> out_data=64'h0000_0000_FFFF_0000; macro undefined, same stimulus -> 64'hFFFF_0000_1234_0000.
REQ-034 Backpressure: out_ready low 5 cycles in DONE -> out_data/out_valid stable, in_ready 0; out_ready high with in_valid high -> result and new request exchange on the same edge.
REQ-035 rst_n pulsed low in second SHIFT cycle of amt=3 request -> outputs 0 immediately, state IDLE, no out_valid afterwards until a new accept.
